// File: rtl/acc_icb_rd_dma.sv
// Read-DMA stage: on a rising 'running' edge, fetches LEN words from SRC_ADDR over an ICB master
// (one read outstanding) and streams them to the compute core through a small FIFO.
module acc_icb_rd_dma #(
    parameter logic [31:0] SRC_ADDR   = 32'h1004_2000,
    parameter int          LEN        = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        running,
    output logic        mst_icb_cmd_valid,
    input  logic        mst_icb_cmd_ready,
    output logic [31:0] mst_icb_cmd_addr,
    output logic        mst_icb_cmd_read,
    output logic [31:0] mst_icb_cmd_wdata,
    output logic [3:0]  mst_icb_cmd_wmask,
    input  logic        mst_icb_rsp_valid,
    output logic        mst_icb_rsp_ready,
    input  logic [31:0] mst_icb_rsp_rdata,
    input  logic        mst_icb_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int             PW      = $clog2(FIFO_DEPTH);
    localparam logic [15:0]    LEN_W   = 16'(LEN);
    localparam logic [PW:0]    DEPTH_W = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]    CNT_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          running_d_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   fifo_cnt_q, fifo_cnt_d;
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic start;
    logic cmd_hs;
    logic rsp_hs;
    logic out_hs;
    logic push;

    assign mst_icb_cmd_read  = 1'b1;
    assign mst_icb_cmd_wdata = 32'h0;
    assign mst_icb_cmd_wmask = 4'h0;

    // cnt only changes in WAIT, so the address is stable for the whole REQ phase
    assign mst_icb_cmd_addr  = SRC_ADDR + {14'd0, cnt_q, 2'b00};
    assign mst_icb_cmd_valid = (state_q == S_REQ) && (fifo_cnt_q < DEPTH_W);
    assign mst_icb_rsp_ready = (state_q == S_WAIT);

    assign out_valid = (fifo_cnt_q != '0);
    assign out_data  = fifo_mem[rd_ptr_q];

    assign busy = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);
    assign err  = (state_q == S_ERR);

    assign start  = running & ~running_d_q;
    assign cmd_hs = mst_icb_cmd_valid & mst_icb_cmd_ready;
    assign rsp_hs = mst_icb_rsp_valid & mst_icb_rsp_ready;
    assign out_hs = out_valid & out_ready;
    assign push   = rsp_hs & ~mst_icb_rsp_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    cnt_d   = 16'd0;
                end
            end
            S_REQ: begin
                if (cmd_hs) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_hs) begin
                    if (mst_icb_rsp_err) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                        state_d = ((cnt_q + 16'd1) == LEN_W) ? S_DRAIN : S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d   = push   ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = out_hs ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        unique case ({push, out_hs})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            running_d_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            running_d_q <= running;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mst_icb_rsp_rdata;
        end
    end

endmodule

// File: tb/tb_acc_icb_rd_dma.sv
// Bench for acc_icb_rd_dma: transaction-level model plus a scripted ICB slave on the main
// instance (LEN=16, depth 4), and a hand-driven LEN=1 / depth-2 instance.
module tb_acc_icb_rd_dma;

    localparam logic [31:0] SRC   = 32'h1004_2000;
    localparam int          LEN   = 16;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, running, cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata, out_data;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_err, out_valid, out_ready, busy, done, err;

    logic        s_rst, s_running, s_cmd_valid, s_cmd_ready, s_cmd_read;
    logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata, s_out_data;
    logic [3:0]  s_cmd_wmask;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_err, s_out_valid, s_out_ready;
    logic        s_busy, s_done, s_err;

    acc_icb_rd_dma #(.SRC_ADDR(SRC), .LEN(LEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .running(running),
        .mst_icb_cmd_valid(cmd_valid), .mst_icb_cmd_ready(cmd_ready),
        .mst_icb_cmd_addr(cmd_addr), .mst_icb_cmd_read(cmd_read),
        .mst_icb_cmd_wdata(cmd_wdata), .mst_icb_cmd_wmask(cmd_wmask),
        .mst_icb_rsp_valid(rsp_valid), .mst_icb_rsp_ready(rsp_ready),
        .mst_icb_rsp_rdata(rsp_rdata), .mst_icb_rsp_err(rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    acc_icb_rd_dma #(.SRC_ADDR(SRC), .LEN(1), .FIFO_DEPTH(2)) dut_small (
        .clk(clk), .rst(s_rst), .running(s_running),
        .mst_icb_cmd_valid(s_cmd_valid), .mst_icb_cmd_ready(s_cmd_ready),
        .mst_icb_cmd_addr(s_cmd_addr), .mst_icb_cmd_read(s_cmd_read),
        .mst_icb_cmd_wdata(s_cmd_wdata), .mst_icb_cmd_wmask(s_cmd_wmask),
        .mst_icb_rsp_valid(s_rsp_valid), .mst_icb_rsp_ready(s_rsp_ready),
        .mst_icb_rsp_rdata(s_rsp_rdata), .mst_icb_rsp_err(s_rsp_err),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .busy(s_busy), .done(s_done), .err(s_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model and compare process ----------------
    logic        mon_on = 1'b0;
    logic        m_started = 1'b0, m_run_prev = 1'b0, m_err = 1'b0;
    int          m_cmd = 0, m_rsp = 0, m_push = 0, m_pop = 0, m_since = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] pop_log[$];
    logic        exp_cv;

    always @(negedge clk) begin
        if (mon_on) begin
            exp_cv = m_started && !m_err && (m_cmd == m_rsp) && (m_cmd < LEN) &&
                     ((m_push - m_pop) < DEPTH);
            chk("cmd_valid", 32'(cmd_valid), 32'(exp_cv));
            if (cmd_valid) chk("cmd_addr", cmd_addr, SRC + 32'(m_cmd * 4));
            chk("rsp_ready", 32'(rsp_ready), 32'(m_cmd != m_rsp));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
            chk("err", 32'(err), 32'(m_err));
            if (!m_started || m_err || m_since >= 2) chk("busy", 32'(busy), 32'd0);
            else if (m_pop < LEN) chk("busy", 32'(busy), 32'd1);
            if (m_pop < LEN || m_err) chk("done", 32'(done), 32'd0);
            else if (m_since >= 2) chk("done", 32'(done), 32'd1);
        end
        if (rst) begin
            m_started = 1'b0; m_run_prev = 1'b0; m_err = 1'b0;
            m_cmd = 0; m_rsp = 0; m_push = 0; m_pop = 0; m_since = 0;
            exp_q.delete(); addr_log.delete(); pop_log.delete();
        end else begin
            if (m_pop == LEN) m_since++;
            if (!m_started && running && !m_run_prev) m_started = 1'b1;
            m_run_prev = running;
            if (cmd_valid && cmd_ready) begin
                addr_log.push_back(cmd_addr);
                m_cmd++;
            end
            if (out_valid && out_ready) begin
                $display("out word %0d data %h", m_pop, out_data);
                pop_log.push_back(out_data);
                m_pop++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (rsp_valid && rsp_ready) begin
                m_rsp++;
                if (rsp_err) m_err = 1'b1;
                else begin
                    exp_q.push_back(mem_word(SRC + 32'(m_push * 4)));
                    m_push++;
                end
            end
        end
    end

    // ---------------- ICB slave for the main instance ----------------
    int          stall_max = 0;
    logic        err_en = 1'b0, hold_en = 1'b0, slave_en = 1'b1;
    logic [31:0] err_addr = '0, hold_addr = '0;
    logic        sl_chs, sl_rhs, sl_rst, sl_pend = 1'b0;
    logic [31:0] sl_caddr, sl_addr = '0;
    int          sl_wait = 0;

    initial begin
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            sl_chs = cmd_valid & cmd_ready;
            sl_rhs = rsp_valid & rsp_ready;
            sl_caddr = cmd_addr;
            sl_rst = rst;
            @(posedge clk);
            #1;
            if (!slave_en || sl_rst) begin
                sl_pend = 1'b0;
                if (slave_en) rsp_valid = 1'b0;
                continue;
            end
            if (sl_rhs) begin
                rsp_valid = 1'b0;
                sl_pend = 1'b0;
            end
            if (sl_chs) begin
                sl_pend = 1'b1;
                sl_addr = sl_caddr;
                sl_wait = (stall_max == 0) ? 0 : int'($urandom_range(0, stall_max));
            end
            cmd_ready = (stall_max == 0) || ($urandom_range(0, 2) != 0);
            if (sl_pend && !rsp_valid && !(hold_en && sl_addr == hold_addr)) begin
                if (sl_wait == 0) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = mem_word(sl_addr);
                    rsp_err = err_en && (sl_addr == err_addr);
                end else begin
                    sl_wait--;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_end(input string name, input int limit);
        for (int i = 0; i < limit && !(done || err); i++) tick();
        chk(name, 32'(done || err), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; running = 1'b0; out_ready = 1'b0;
        s_rst = 1'b1; s_running = 1'b0; s_cmd_ready = 1'b1; s_rsp_valid = 1'b0;
        s_rsp_rdata = '0; s_rsp_err = 1'b0; s_out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        // 1: zero-wait slave, consumer always ready
        tick();
        out_ready = 1'b1;
        running = 1'b1;
        @(negedge clk);
        chk("t1_cv_before_sample", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        chk("t1_cv_after_sample", 32'(cmd_valid), 32'd1);
        chk("t1_tied", {31'd0, cmd_read} ^ {cmd_wdata[27:0], cmd_wmask}, 32'd1);
        wait_end("t1_finish", 200);
        chk("t1_ncmd", 32'(addr_log.size()), 32'd16);
        chk("t1_addr0", addr_log[0], 32'h1004_2000);
        chk("t1_addr15", addr_log[15], 32'h1004_203C);
        chk("t1_npop", 32'(pop_log.size()), 32'd16);
        chk("t1_data0", pop_log[0], 32'h2000_DFFF);
        chk("t1_data15", pop_log[15], 32'h203C_DFC3);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: consumer stalled -> FIFO fills after 4 commands; running held high through reset
        out_ready = 1'b0;
        do_reset();
        repeat (40) tick();
        chk("t2_ncmd_full", 32'(addr_log.size()), 32'd4);
        chk("t2_cv_off", 32'(cmd_valid), 32'd0);
        out_ready = 1'b1;
        wait_end("t2_finish", 300);
        chk("t2_npop", 32'(pop_log.size()), 32'd16);
        chk("t2_data4", pop_log[4], 32'h2010_DFEF);
        chk("t2_done", 32'(done), 32'd1);

        // 3: random ICB stalls and consumer back-pressure
        stall_max = 5;
        do_reset();
        for (int i = 0; i < 2000 && !done; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        wait_end("t3_finish", 50);
        chk("t3_npop", 32'(pop_log.size()), 32'd16);
        chk("t3_done", 32'(done), 32'd1);
        stall_max = 0;

        // 4: error response on word 5
        err_en = 1'b1;
        err_addr = SRC + 32'd20;
        do_reset();
        wait_end("t4_finish", 200);
        repeat (10) tick();
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_ncmd", 32'(addr_log.size()), 32'd6);
        chk("t4_npop", 32'(pop_log.size()), 32'd5);
        chk("t4_data4", pop_log[4], 32'h2010_DFEF);
        err_en = 1'b0;

        // 5: reset while waiting on word 7, with a late response presented after reset
        hold_en = 1'b1;
        hold_addr = SRC + 32'd28;
        do_reset();
        for (int i = 0; i < 200 && addr_log.size() < 8; i++) tick();
        chk("t5_reach_w7", 32'(addr_log.size()), 32'd8);
        tick();
        @(negedge clk);
        chk("t5_in_wait", 32'(rsp_ready), 32'd1);
        tick();
        slave_en = 1'b0;
        rst = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hBAD0_0007;
        rsp_err = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        tick();
        rsp_valid = 1'b0;
        hold_en = 1'b0;
        slave_en = 1'b1;
        wait_end("t5_finish", 200);
        chk("t5_addr0", addr_log[0], 32'h1004_2000);
        chk("t5_npop", 32'(pop_log.size()), 32'd16);
        chk("t5_data0", pop_log[0], 32'h2000_DFFF);

        // 6: LEN=1, depth-2 instance, hand-driven
        s_rst = 1'b0;
        s_running = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_cv", 32'(s_cmd_valid), 32'd1);
        chk("t6_addr", s_cmd_addr, 32'h1004_2000);
        chk("t6_busy", 32'(s_busy), 32'd1);
        tick();
        s_rsp_valid = 1'b1;
        s_rsp_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("t6_rsp_ready", 32'(s_rsp_ready), 32'd1);
        chk("t6_cv_wait", 32'(s_cmd_valid), 32'd0);
        tick();
        s_rsp_valid = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 32'(s_out_valid), 32'd1);
        chk("t6_out_data", s_out_data, 32'hCAFE_0001);
        repeat (3) tick();
        chk("t6_done_held", 32'(s_done), 32'd0);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("t6_done", 32'(s_done), 32'd1);
        chk("t6_busy_off", 32'(s_busy), 32'd0);
        chk("t6_out_empty", 32'(s_out_valid), 32'd0);
        tick();
        s_running = 1'b0;
        tick(); tick();
        s_running = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_rerun", 32'(s_cmd_valid), 32'd0);
        end
        chk("t6_done_sticky", 32'(s_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
